// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMsbIn = CntW'(WIDTH - 2);
    localparam logic [CntW-1:0] CntLast  = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_c_msb_in;
    logic             r_carry_out;
    logic             r_overflow;
    logic [CntW-1:0]  r_count;

    logic w_s;
    logic w_co;
    logic w_p;

    // Single full-adder cell shared across all bit positions.
    assign w_p  = r_a_sh[0] ^ r_b_sh[0];
    assign w_s  = w_p ^ r_c;
    assign w_co = (r_a_sh[0] & r_b_sh[0]) | (r_c & w_p);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (r_count == CntLast) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_result    <= '0;
            r_c         <= 1'b0;
            r_c_msb_in  <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else begin
            if (r_state == StIdle && in_valid) begin
                // Subtract is A + ~B + ~borrow_in.
                r_a_sh  <= op_a;
                r_b_sh  <= sub ? ~op_b : op_b;
                r_c     <= carry_in ^ sub;
                r_count <= '0;
            end else if (r_state == StRun) begin
                r_result <= {w_s, r_result[WIDTH-1:1]};
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_c      <= w_co;
                r_count  <= r_count + CntW'(1);
                if (r_count == CntMsbIn) begin
                    r_c_msb_in <= w_co;
                end
                if (r_count == CntLast) begin
                    r_carry_out <= w_co;
                    r_overflow  <= w_co ^ r_c_msb_in;
                end
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic/protocol model plus directed vectors.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: result from integer arithmetic, timing from the handshake contract.
    bit           chk_en = 1'b0;
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] p_res, e_res;
    logic         p_c, e_c, p_v, e_v;

    always @(posedge clk) begin
        int ua, ub, ci, sa, sb, uv, sv;
        if (!reset_n) begin
            m_left = 0;
            m_done = 1'b0;
            e_res  = '0;
            e_c    = 1'b0;
            e_v    = 1'b0;
            chk_en = 1'b1;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                e_res  = p_res;
                e_c    = p_c;
                e_v    = p_v;
            end
        end else if (in_valid) begin
            ua = int'(op_a);
            ub = int'(op_b);
            ci = int'(carry_in);
            sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
            sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
            uv = sub ? ua - ub - ci : ua + ub + ci;
            sv = sub ? sa - sb - ci : sa + sb + ci;
            p_res  = W'(uv);
            p_c    = sub ? (uv >= 0) : (uv >= (1 << W));
            p_v    = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
            m_left = W;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", in_ready, (!m_done && m_left == 0));
            chk("cyc_out_valid", out_valid, m_done);
            chk("cyc_busy", busy, (m_done || m_left > 0));
            if (m_left == 0) begin
                chk("cyc_result", result, e_res);
                chk("cyc_carry_out", carry_out, e_c);
                chk("cyc_overflow", overflow, e_v);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sb);
        int t = 0;
        while (!in_ready && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        chk("start_in_ready", in_ready, 1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        carry_in = ci;
        sub      = sb;
        @(posedge clk); #1;
        // Operands are only sampled at the accept edge; scramble them afterwards.
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        carry_in = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic wait_check(input string nm, input logic [W-1:0] r, input logic c,
                              input logic v);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, W);
        chk({nm, "_result"}, result, r);
        chk({nm, "_carry"}, carry_out, c);
        chk({nm, "_ovf"}, overflow, v);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        int pulses;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        op_a      = 8'hFF;
        op_b      = 8'h00;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        @(posedge clk); #1;
        chk("rst_no_start", busy, 0);

        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_check("add_ovf", 8'h96, 1'b0, 1'b1);
        release_out();

        start_op(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_check("add_carry", 8'h01, 1'b1, 1'b0);
        release_out();

        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        wait_check("sub_neg", 8'hF0, 1'b0, 1'b0);
        release_out();

        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_check("sub_ovf", 8'h7F, 1'b1, 1'b1);

        // Hold the result under backpressure while offering a new request.
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            op_a     = 8'hAA;
            op_b     = 8'h55;
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_result", result, 8'h7F);
            chk("bp_carry", carry_out, 1);
            chk("bp_ovf", overflow, 1);
        end
        in_valid = 1'b0;
        release_out();
        @(posedge clk); #1;
        chk("bp_not_accepted", busy, 0);

        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("midrst_no_valid", pulses, 0);
        chk("midrst_idle", busy, 0);
        chk("midrst_result", result, 8'h00);

        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        wait_check("post_rst_add", 8'h46, 1'b0, 1'b0);
        release_out();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
